// File: rtl/axi_req_bridge.sv
// axi_req_bridge: converts a simple valid/ready request/response port into single-beat AXI4
// transactions towards a memory wrapper. One transaction is outstanding at a time.
//
// Ports
//   clk, arst              clock; asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_we selects write (1) or read (0)
//   req_addr/wdata/wstrb   request payload, captured on acceptance
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     read data (0 for writes and errors), error flag
//   axi_mosi, axi_miso     AXI4 master request / slave response channel bundles

package axi_req_bridge_pkg;

  localparam int unsigned AxiIdW    = 4;
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  BurstIncr = 2'b01;

  typedef struct packed {
    // write address
    logic [AxiIdW-1:0] awid;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    // write data
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    // write response
    logic              bready;
    // read address
    logic [AxiIdW-1:0] arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    // read data
    logic              rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic              awready;
    logic              wready;
    logic [AxiIdW-1:0] bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              arready;
    logic [AxiIdW-1:0] rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
  } s_axi_miso_t;

endpackage

module axi_req_bridge
  import axi_req_bridge_pkg::*;
#(
  parameter int unsigned MEM_KB = 4,
  parameter int unsigned AXI_ID = 0
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);

  // One extra bit so a 4 GB window cannot wrap to zero.
  localparam logic [32:0] MemBytes = 33'(MEM_KB) * 33'd1024;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StRsp
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        aw_valid, w_valid, aw_hs, w_hs;
  logic        in_window;
  logic        rd_err;

  assign in_window = ({1'b0, req_addr} < MemBytes);

  // AW and W are tracked independently; each drops right after its own handshake.
  assign aw_valid = (state_q == StWrReq) && !aw_done_q;
  assign w_valid  = (state_q == StWrReq) && !w_done_q;
  assign aw_hs    = aw_valid && axi_miso.awready;
  assign w_hs     = w_valid && axi_miso.wready;

  assign rd_err   = (axi_miso.rresp != RespOkay);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (!in_window) begin
            // Out-of-window requests never reach the AXI side.
            state_d     = StRsp;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we) begin
            state_d = StWrReq;
          end else begin
            state_d = StRdReq;
          end
        end
      end

      StWrReq: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = StWrResp;
        end
      end

      StWrResp: begin
        if (axi_miso.bvalid) begin
          state_d     = StRsp;
          rsp_err_d   = (axi_miso.bresp != RespOkay);
          rsp_rdata_d = '0;
        end
      end

      StRdReq: begin
        if (axi_miso.arready) begin
          state_d = StRdData;
        end
      end

      StRdData: begin
        if (axi_miso.rvalid) begin
          state_d     = StRsp;
          rsp_err_d   = rd_err;
          // Errored reads return zero data rather than whatever the slave drove.
          rsp_rdata_d = rd_err ? '0 : axi_miso.rdata;
        end
      end

      StRsp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Payload comes straight from the captured registers, so it is stable while valid is high.
  always_comb begin
    axi_mosi = '0;

    axi_mosi.awid    = AxiIdW'(AXI_ID);
    axi_mosi.awaddr  = addr_q & ~32'h3;
    axi_mosi.awlen   = 8'd0;
    axi_mosi.awsize  = 3'd2;
    axi_mosi.awburst = BurstIncr;
    axi_mosi.awlock  = 1'b0;
    axi_mosi.awcache = 4'd0;
    axi_mosi.awprot  = 3'd0;
    axi_mosi.awvalid = aw_valid;

    axi_mosi.wdata   = wdata_q;
    axi_mosi.wstrb   = wstrb_q;
    axi_mosi.wlast   = 1'b1;
    axi_mosi.wvalid  = w_valid;

    axi_mosi.bready  = (state_q == StWrResp);

    axi_mosi.arid    = AxiIdW'(AXI_ID);
    axi_mosi.araddr  = addr_q & ~32'h3;
    axi_mosi.arlen   = 8'd0;
    axi_mosi.arsize  = 3'd2;
    axi_mosi.arburst = BurstIncr;
    axi_mosi.arlock  = 1'b0;
    axi_mosi.arcache = 4'd0;
    axi_mosi.arprot  = 3'd0;
    axi_mosi.arvalid = (state_q == StRdReq);

    axi_mosi.rready  = (state_q == StRdData);
  end

  // IDs and rlast carry no information for single-beat, single-ID traffic.
  logic unused_miso;
  assign unused_miso = ^{axi_miso.bid, axi_miso.rid, axi_miso.rlast};

endmodule

// File: tb/tb_axi_req_bridge.sv
module tb_axi_req_bridge;
  import axi_req_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_req_bridge #(
    .MEM_KB(4),
    .AXI_ID(0)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .axi_mosi (axi_mosi),
    .axi_miso (axi_miso)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Memory slave model. Knobs are written only by the stimulus block, model state only here.
  // Decisions are made on the falling edge and take effect at the following rising edge.
  // ---------------------------------------------------------------------------------------------
  int         aw_delay = 0;
  int         r_delay = 0;
  logic [1:0] bresp_knob = 2'b00;
  logic [1:0] rresp_knob = 2'b00;

  logic [31:0] mem [1024];
  int          aw_wait = 0, r_wait = 0;
  logic        aw_got = 0, w_got = 0, b_pend = 0, b_fire = 0, r_pend = 0, r_fire = 0;
  int          aw_hi_cnt = 0, w_hi_cnt = 0, ar_hi_cnt = 0, b_hs_cnt = 0;
  logic [31:0] cap_awaddr = '0, cap_araddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        cap_wlast = 1'b0;
  logic [31:0] cap_awfix = '0, cap_arfix = '0;

  always @(negedge clk) begin
    if (!arst) begin
      axi_miso = '0;
      aw_wait  = 0;
      r_wait   = 0;
      aw_got   = 0;
      w_got    = 0;
      b_pend   = 0;
      b_fire   = 0;
      r_pend   = 0;
      r_fire   = 0;
    end else begin
      // retire B/R beats accepted at the last rising edge
      if (b_fire) begin axi_miso.bvalid = 1'b0; b_fire = 0; end
      if (r_fire) begin axi_miso.rvalid = 1'b0; r_fire = 0; end
      if (b_pend && !axi_miso.bvalid) begin
        axi_miso.bvalid = 1'b1;
        axi_miso.bresp  = bresp_knob;
        b_pend = 0;
      end
      if (r_pend && !axi_miso.rvalid) begin
        if (r_wait >= r_delay) begin
          axi_miso.rvalid = 1'b1;
          axi_miso.rdata  = mem[cap_araddr[11:2]];
          axi_miso.rresp  = rresp_knob;
          axi_miso.rlast  = 1'b1;
          r_pend = 0;
          r_wait = 0;
        end else begin
          r_wait++;
        end
      end
      if (axi_miso.bvalid && axi_mosi.bready) begin b_fire = 1; b_hs_cnt++; end
      if (axi_miso.rvalid && axi_mosi.rready) r_fire = 1;

      if (axi_mosi.awvalid) aw_hi_cnt++;
      axi_miso.awready = axi_mosi.awvalid && (aw_wait >= aw_delay);
      if (axi_mosi.awvalid && !axi_miso.awready) aw_wait++;
      if (axi_mosi.awvalid && axi_miso.awready) begin
        aw_wait    = 0;
        aw_got     = 1;
        cap_awaddr = axi_mosi.awaddr;
        cap_awfix  = {7'd0, axi_mosi.awid, axi_mosi.awlen, axi_mosi.awsize, axi_mosi.awburst,
                      axi_mosi.awlock, axi_mosi.awcache, axi_mosi.awprot};
      end

      if (axi_mosi.wvalid) w_hi_cnt++;
      axi_miso.wready = axi_mosi.wvalid;
      if (axi_mosi.wvalid) begin
        w_got     = 1;
        cap_wdata = axi_mosi.wdata;
        cap_wstrb = axi_mosi.wstrb;
        cap_wlast = axi_mosi.wlast;
      end

      if (aw_got && w_got) begin
        for (int i = 0; i < 4; i++) begin
          if (cap_wstrb[i]) mem[cap_awaddr[11:2]][8*i +: 8] = cap_wdata[8*i +: 8];
        end
        b_pend = 1;
        aw_got = 0;
        w_got  = 0;
      end

      if (axi_mosi.arvalid) ar_hi_cnt++;
      axi_miso.arready = axi_mosi.arvalid;
      if (axi_mosi.arvalid) begin
        cap_araddr = axi_mosi.araddr;
        cap_arfix  = {7'd0, axi_mosi.arid, axi_mosi.arlen, axi_mosi.arsize, axi_mosi.arburst,
                      axi_mosi.arlock, axi_mosi.arcache, axi_mosi.arprot};
        r_pend = 1;
        r_wait = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Request / response helpers (start and end on a falling edge)
  // ---------------------------------------------------------------------------------------------
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [4:0] axi_vr;
  assign axi_vr = {axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.bready, axi_mosi.arvalid,
                   axi_mosi.rready};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          s_aw, s_w, s_b, s_ar, n;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_axi_vr", 32'(axi_vr), 32'd0);
    arst = 1'b1;

    // write 0x10
    s_b = b_hs_cnt; s_aw = aw_hi_cnt;
    send_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    get_rsp(rd, er);
    check("wr_err", 32'(er), 32'd0);
    check("wr_rdata", rd, 32'd0);
    check("wr_awaddr", cap_awaddr, 32'h10);
    check("wr_wdata", cap_wdata, 32'hDEADBEEF);
    check("wr_wstrb_wlast", {27'd0, cap_wstrb, cap_wlast}, {27'd0, 4'hF, 1'b1});
    check("wr_awfix", cap_awfix, {7'd0, 4'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0});
    check("wr_one_b", 32'(b_hs_cnt - s_b), 32'd1);
    check("wr_aw_cycles", 32'(aw_hi_cnt - s_aw), 32'd1);

    // read 0x10
    send_req(1'b0, 32'h10, 32'h0, 4'h0);
    get_rsp(rd, er);
    check("rd_araddr", cap_araddr, 32'h10);
    check("rd_arfix", cap_arfix, {7'd0, 4'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0});
    check("rd_rdata", rd, 32'hDEADBEEF);
    check("rd_err", 32'(er), 32'd0);

    // out-of-window read: response one cycle after acceptance, no AR
    s_ar = ar_hi_cnt;
    send_req(1'b0, 32'h1000, 32'h0, 4'h0);
    check("oow_rd_one_cycle", 32'(rsp_valid), 32'd1);
    get_rsp(rd, er);
    check("oow_rd_err", 32'(er), 32'd1);
    check("oow_rd_rdata", rd, 32'd0);
    check("oow_rd_no_ar", 32'(ar_hi_cnt - s_ar), 32'd0);

    // out-of-window write at top of address space
    s_aw = aw_hi_cnt; s_w = w_hi_cnt;
    send_req(1'b1, 32'hFFFF_FFFF, 32'h1234, 4'hF);
    get_rsp(rd, er);
    check("oow_wr_err", 32'(er), 32'd1);
    check("oow_wr_no_aw_w", 32'((aw_hi_cnt - s_aw) + (w_hi_cnt - s_w)), 32'd0);

    // unaligned write, then partial-strobe write, then unaligned read
    send_req(1'b1, 32'h13, 32'h11223344, 4'hF);
    get_rsp(rd, er);
    check("unal_awaddr", cap_awaddr, 32'h10);
    send_req(1'b1, 32'h10, 32'hAABBCCDD, 4'h3);
    get_rsp(rd, er);
    send_req(1'b0, 32'h12, 32'h0, 4'h0);
    get_rsp(rd, er);
    check("unal_araddr", cap_araddr, 32'h10);
    check("strb_rdata", rd, 32'h1122CCDD);

    // last legal word
    send_req(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF);
    get_rsp(rd, er);
    check("top_wr_err", 32'(er), 32'd0);
    send_req(1'b0, 32'hFFC, 32'h0, 4'h0);
    get_rsp(rd, er);
    check("top_rd_rdata", rd, 32'hCAFEF00D);
    check("top_rd_err", 32'(er), 32'd0);

    // awready delayed by 3 cycles, wready immediate
    aw_delay = 3;
    s_aw = aw_hi_cnt; s_w = w_hi_cnt; s_b = b_hs_cnt;
    send_req(1'b1, 32'h20, 32'h0000_0005, 4'hF);
    get_rsp(rd, er);
    aw_delay = 0;
    check("slow_aw_cycles", 32'(aw_hi_cnt - s_aw), 32'd4);
    check("slow_w_cycles", 32'(w_hi_cnt - s_w), 32'd1);
    check("slow_one_b", 32'(b_hs_cnt - s_b), 32'd1);
    check("slow_err", 32'(er), 32'd0);

    // error responses from the slave
    bresp_knob = 2'b10;
    send_req(1'b1, 32'h24, 32'h77, 4'hF);
    get_rsp(rd, er);
    bresp_knob = 2'b00;
    check("slverr_wr_err", 32'(er), 32'd1);
    check("slverr_wr_rdata", rd, 32'd0);
    rresp_knob = 2'b11;
    send_req(1'b0, 32'h10, 32'h0, 4'h0);
    get_rsp(rd, er);
    rresp_knob = 2'b00;
    check("decerr_rd_err", 32'(er), 32'd1);

    // response backpressure for 5 cycles
    send_req(1'b0, 32'h10, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_flags", {29'd0, rsp_valid, req_ready, rsp_err}, 32'b100);
      check("hold_rdata", rsp_rdata, 32'h1122CCDD);
      @(negedge clk);
    end
    get_rsp(rd, er);
    check("hold_final_rdata", rd, 32'h1122CCDD);

    // reset while waiting for read data
    r_delay = 8;
    send_req(1'b0, 32'h10, 32'h0, 4'h0);
    n = 0;
    while (!axi_mosi.rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_in_rd_data", 32'(axi_mosi.rready), 32'd1);
    arst = 1'b0;
    #1;
    check("mid_rst_axi_vr", 32'(axi_vr), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    r_delay = 0;
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", {30'd0, rsp_valid, req_ready}, 32'b01);
    check("post_rst_axi_vr", 32'(axi_vr), 32'd0);
    send_req(1'b0, 32'h10, 32'h0, 4'h0);
    get_rsp(rd, er);
    check("post_rst_rdata", rd, 32'h1122CCDD);
    check("post_rst_err", 32'(er), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
